// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the CPU memory bus between the fetch port and
// the load/store port, fixed priority with a fairness override.
module cpu_bus_arbiter #(
    parameter int PRIORITY_DATA  = 1,
    parameter int FAIRNESS_LIMIT = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,

    input  logic        i_inst_request,
    input  logic [31:0] i_inst_address,
    output logic        o_inst_ready,
    output logic [31:0] o_inst_rdata,

    input  logic        i_data_request,
    input  logic        i_data_rw,
    input  logic [31:0] i_data_address,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_wmask,
    output logic        o_data_ready,
    output logic [31:0] o_data_rdata,

    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,

    output logic [1:0]  o_grant
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_GRANT_INST = 2'd1;
    localparam logic [1:0] S_GRANT_DATA = 2'd2;
    localparam logic [1:0] S_RELEASE    = 2'd3;

    localparam int CW = (FAIRNESS_LIMIT > 0) ? $clog2(FAIRNESS_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(FAIRNESS_LIMIT);
    localparam bit PRI_DATA = (PRIORITY_DATA != 0);
    localparam bit FAIR_EN  = (FAIRNESS_LIMIT > 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] fair_q, fair_d;

    logic       pri_req, oth_req;
    logic [1:0] pri_state, oth_state;
    logic       fair_hit;
    logic       inst_own, data_own;

    assign pri_req   = PRI_DATA ? i_data_request : i_inst_request;
    assign oth_req   = PRI_DATA ? i_inst_request : i_data_request;
    assign pri_state = PRI_DATA ? S_GRANT_DATA : S_GRANT_INST;
    assign oth_state = PRI_DATA ? S_GRANT_INST : S_GRANT_DATA;
    assign fair_hit  = FAIR_EN && (fair_q == LIMIT);

    always_comb begin
        state_d = state_q;
        fair_d  = fair_q;
        case (state_q)
            S_IDLE: begin
                if (pri_req && oth_req) begin
                    // the waiting port gets one turn after LIMIT contended wins
                    if (fair_hit) begin
                        state_d = oth_state;
                        fair_d  = '0;
                    end else begin
                        state_d = pri_state;
                        if (fair_q != LIMIT) begin
                            fair_d = fair_q + 1'b1;
                        end
                    end
                end else if (pri_req) begin
                    state_d = pri_state;
                    fair_d  = '0;
                end else if (oth_req) begin
                    state_d = oth_state;
                    fair_d  = '0;
                end
            end
            S_GRANT_INST, S_GRANT_DATA: begin
                if (i_bus_ready) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            fair_q  <= '0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
        end
    end

    assign inst_own = (state_q == S_GRANT_INST);
    assign data_own = (state_q == S_GRANT_DATA);

    assign o_bus_request = inst_own | data_own;
    assign o_grant       = {data_own, inst_own};

    assign o_bus_rw      = data_own & i_data_rw;
    assign o_bus_address = data_own ? i_data_address :
                           inst_own ? i_inst_address : 32'h0;
    assign o_bus_wdata   = data_own ? i_data_wdata : 32'h0;
    assign o_bus_wmask   = data_own ? i_data_wmask : 4'h0;

    assign o_inst_ready  = inst_own & i_bus_ready;
    assign o_data_ready  = data_own & i_bus_ready;
    assign o_inst_rdata  = i_bus_rdata;
    assign o_data_rdata  = i_bus_rdata;

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single CPU memory bus between two requesters:
  - the instruction-fetch port (icache/fetch bus master);
  - the data port (load/store unit).
- Sits between the CPU core and the system bus.
- Uses the same level-request / single-cycle-ready handshake on both sides.
- Arbitration is fixed-priority with a configurable fairness limit, so neither port starves.

Parameters:
- PRIORITY_DATA, 1: 1 gives the data port priority when both ports request; 0 gives the instruction port priority.
- FAIRNESS_LIMIT, 4: maximum consecutive grants to the priority port while the other port is waiting. 0 means strict priority (no fairness override).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_inst_request  in  1  instruction port request (level, held until ready)
- i_inst_address  in  32  instruction read address
- o_inst_ready  out  1  one-cycle pulse: instruction read complete
- o_inst_rdata  out  32  instruction read data, valid with o_inst_ready
- i_data_request  in  1  data port request (level)
- i_data_rw  in  1  1 = write, 0 = read
- i_data_address  in  32  data address
- i_data_wdata  in  32  write data
- i_data_wmask  in  4  byte write enables
- o_data_ready  out  1  one-cycle pulse: data access complete
- o_data_rdata  out  32  read data, valid with o_data_ready
- o_bus_request  out  1  bus request (level)
- o_bus_rw  out  1  bus direction
- o_bus_address  out  32  bus address
- o_bus_wdata  out  32  bus write data
- o_bus_wmask  out  4  bus byte enables
- i_bus_ready  in  1  bus completion pulse
- i_bus_rdata  in  32  bus read data
- o_grant  out  2  current owner: bit0 = instruction port, bit1 = data port; one-hot or zero

Behaviour:

Reset values:
- state IDLE, fairness counter 0.
- o_bus_request 0, o_grant 0, o_inst_ready 0, o_data_ready 0.
- Reset mid-transaction: next edge forces IDLE and drops o_bus_request. No ready pulse is issued for the abandoned access.

States: IDLE, GRANT_INST, GRANT_DATA, RELEASE.

IDLE (decision cycle):
- Only one port requesting: that port is granted.
- Both ports requesting:
  - the priority port wins, unless FAIRNESS_LIMIT > 0 and the counter equals FAIRNESS_LIMIT;
  - in that case the non-priority port wins and the counter clears.
- Counter update:
  - priority port granted while the other port was also requesting: counter +1, saturating at FAIRNESS_LIMIT;
  - priority port granted with no contention: counter clears;
  - non-priority port granted: counter clears.
- Neither port requesting: stay in IDLE.

GRANT_x:
- o_bus_request = 1, o_grant = owner.
- o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask are driven combinationally from the owner port.
- For the instruction port, rw = 0, wmask = 0, wdata = 0.
- Owner inputs must stay stable while granted. The arbiter keeps o_bus_request asserted until i_bus_ready even if the owner drops its request.

Completion:
- i_bus_ready in GRANT_x drives the owner's o_x_ready = 1 in the same cycle (combinational pass-through).
- The next state is RELEASE.
- The non-owner port never sees ready.

Read data:
- o_inst_rdata and o_data_rdata both equal i_bus_rdata at all times; data is only meaningful with the corresponding ready.

RELEASE:
- One cycle with o_bus_request = 0 and o_grant = 0, then IDLE.
- This lets requesters drop their request after ready, so a stale request is never regranted.

Timing:
- Minimum latency from request to o_bus_request is 2 cycles (IDLE decision, then GRANT).
- Back-to-back throughput is one access per (bus latency + 3) cycles.
- i_bus_ready outside GRANT_x is ignored.

Test Plan:
1. Instruction-only request at 0x0000_1000; bus ready 3 cycles after o_bus_request:
   - o_bus_address = 0x1000, o_bus_rw = 0, o_grant = 01;
   - o_inst_ready pulses once with rdata 0xDEADBEEF;
   - o_data_ready stays 0.
2. Data write to 0x2000, wdata 0x12345678, wmask 0011:
   - bus outputs mirror these values, o_grant = 10;
   - o_data_ready pulses once;
   - one RELEASE cycle with o_bus_request = 0 follows.
3. Both ports requesting continuously, PRIORITY_DATA = 1, FAIRNESS_LIMIT = 4:
   - grant sequence is D, D, D, D, I, repeating.
4. Both ports requesting, FAIRNESS_LIMIT = 0:
   - data is always granted; the instruction port is granted only after data deasserts.
5. i_reset asserted in GRANT_DATA before ready:
   - next cycle o_bus_request = 0 and o_grant = 00, with no ready pulse;
   - after reset deasserts, a pending instruction request is granted 2 cycles later.
6. Owner drops its request mid-grant:
   - o_bus_request stays 1 until i_bus_ready;
   - the ready pulse goes to the original owner, then RELEASE.
